// File: rtl/lrclk.sv
`default_nettype none
// ============================================================================
// Module   : lrclk
// Purpose  : I2S / audio-codec clock generator. Divides the system clock into
//            a 50% duty serial bit clock (clk2, BCLK) and a left/right word
//            select (clk3, LRCK). It also gives the serializer one-cycle
//            strobes and the current bit slot so it can shift in step with
//            the codec. Pure timing source; carries no audio data.
// Ports    : clk        - system clock, all logic on the rising edge
//            rst_n      - asynchronous active-low reset
//            clk2       - bit clock (BCLK), registered
//            clk3       - word select (LRCK), 0 = left, 1 = right, registered
//            bclk_fall  - strobe, first clk cycle with clk2 low after a fall
//            lr_toggle  - strobe, first clk cycle after any clk3 change
//            bit_idx    - bit slot within the channel, 0 = first after LRCK edge
//            mclk       - codec master clock (only with LRCLK_MCLK_EN)
// Options  : define LRCLK_MCLK_EN to add the mclk output and its divider.
// Revision : 1.0 - initial release
// ============================================================================
module lrclk #(
   parameter int BCLK_HALF        = 8,
   parameter int BITS_PER_CHANNEL = 32
`ifdef LRCLK_MCLK_EN
   ,
   parameter int MCLK_HALF        = 2
`endif
) (
   input  logic                                clk,
   input  logic                                rst_n,
   output logic                                clk2,
   output logic                                clk3,
   output logic                                bclk_fall,
   output logic                                lr_toggle,
   output logic [$clog2(BITS_PER_CHANNEL)-1:0] bit_idx
`ifdef LRCLK_MCLK_EN
   ,
   output logic                                mclk
`endif
);

   localparam int c_DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int c_BIT_W = $clog2(BITS_PER_CHANNEL);

   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_HALF - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(BITS_PER_CHANNEL - 1);

   logic [c_DIV_W-1:0] r_div_cnt;
   logic [c_BIT_W-1:0] r_bit_idx;
   logic               r_clk2;
   logic               r_clk3;
   logic               r_bclk_fall;
   logic               r_lr_toggle;

   logic w_div_wrap;
   logic w_fall;
   logic w_bit_wrap;

   assign w_div_wrap = (r_div_cnt == c_DIV_LAST);
   // clk2 is about to go 1->0 on this edge
   assign w_fall     = w_div_wrap & r_clk2;
   assign w_bit_wrap = (r_bit_idx == c_BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt   <= '0;
         r_bit_idx   <= '0;
         r_clk2      <= 1'b0;
         r_clk3      <= 1'b0;
         r_bclk_fall <= 1'b0;
         r_lr_toggle <= 1'b0;
      end else begin
         if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_clk2    <= ~r_clk2;
         end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
         end

         // Bit slot and LRCK advance only on BCLK falling edges, so LRCK
         // always changes together with a clk2 fall.
         if (w_fall) begin
            if (w_bit_wrap) begin
               r_bit_idx <= '0;
               r_clk3    <= ~r_clk3;
            end else begin
               r_bit_idx <= r_bit_idx + c_BIT_W'(1);
            end
         end

         // Strobes are registered on the same edge that moves clk2/clk3,
         // so they are high in the first cycle the new level is visible.
         r_bclk_fall <= w_fall;
         r_lr_toggle <= w_fall & w_bit_wrap;
      end
   end

   assign clk2      = r_clk2;
   assign clk3      = r_clk3;
   assign bclk_fall = r_bclk_fall;
   assign lr_toggle = r_lr_toggle;
   assign bit_idx   = r_bit_idx;

`ifdef LRCLK_MCLK_EN
   // mclk is derived from a phase counter spanning one full mclk period.
   // The counter is preset so that it reaches the rising phase point
   // (c_MHALF) on the same edge div_cnt first returns to 0 after reset.
   localparam int c_MPER   = 2 * MCLK_HALF;
   localparam int c_MPH_W  = $clog2(c_MPER);
   localparam int c_MPH_P0 = (MCLK_HALF - (BCLK_HALF % c_MPER) + c_MPER) % c_MPER;

   localparam logic [c_MPH_W-1:0] c_MPH_LAST  = c_MPH_W'(c_MPER - 1);
   localparam logic [c_MPH_W-1:0] c_MHALF     = c_MPH_W'(MCLK_HALF);
   localparam logic [c_MPH_W-1:0] c_MPH_RESET = c_MPH_W'(c_MPH_P0);

   logic [c_MPH_W-1:0] r_mph;
   logic               r_mclk;
   logic [c_MPH_W-1:0] w_mph_next;

   assign w_mph_next = (r_mph == c_MPH_LAST) ? '0 : (r_mph + c_MPH_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mph  <= c_MPH_RESET;
         r_mclk <= 1'b0;
      end else begin
         r_mph <= w_mph_next;
         // High half of the phase, but only entered at the rising phase
         // point: avoids a truncated first pulse right after reset.
         r_mclk <= (w_mph_next >= c_MHALF) & (r_mclk | (w_mph_next == c_MHALF));
      end
   end

   assign mclk = r_mclk;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lrclk.sv
`default_nettype none
// ============================================================================
// Module   : tb_lrclk
// Purpose  : Directed self-checking bench for lrclk. Runs the default
//            configuration and a BCLK_HALF=1 / BITS_PER_CHANNEL=4 instance
//            side by side and compares every cycle against closed-form
//            expectations counted in rising edges since reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lrclk;

   logic       clk;
   logic       rst_n;

   logic       clk2, clk3, bclk_fall, lr_toggle;
   logic [4:0] bit_idx;
   logic       d2_clk2, d2_clk3, d2_bclk_fall, d2_lr_toggle;
   logic [1:0] d2_bit_idx;
`ifdef LRCLK_MCLK_EN
   logic       mclk;
   logic       d2_mclk;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   lrclk dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk2      (clk2),
      .clk3      (clk3),
      .bclk_fall (bclk_fall),
      .lr_toggle (lr_toggle),
      .bit_idx   (bit_idx)
`ifdef LRCLK_MCLK_EN
      ,
      .mclk      (mclk)
`endif
   );

   lrclk #(
      .BCLK_HALF        (1),
      .BITS_PER_CHANNEL (4)
   ) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk2      (d2_clk2),
      .clk3      (d2_clk3),
      .bclk_fall (d2_bclk_fall),
      .lr_toggle (d2_lr_toggle),
      .bit_idx   (d2_bit_idx)
`ifdef LRCLK_MCLK_EN
      ,
      .mclk      (d2_mclk)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input int n, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_clk2"},      0, 32'(clk2),      0);
      chk({tag, "_clk3"},      0, 32'(clk3),      0);
      chk({tag, "_bclk_fall"}, 0, 32'(bclk_fall), 0);
      chk({tag, "_lr_toggle"}, 0, 32'(lr_toggle), 0);
      chk({tag, "_bit_idx"},   0, 32'(bit_idx),   0);
      chk({tag, "_d2_clk2"},   0, 32'(d2_clk2),   0);
      chk({tag, "_d2_clk3"},   0, 32'(d2_clk3),   0);
      chk({tag, "_d2_bit_idx"},0, 32'(d2_bit_idx),0);
`ifdef LRCLK_MCLK_EN
      chk({tag, "_mclk"},      0, 32'(mclk),      0);
`endif
   endtask

   // n = number of rising clk edges since reset release.
   // Default: clk2 half = 8 edges, bit slot = 16 edges, clk3 half = 512 edges.
   // dut2:    clk2 half = 1 edge,  bit slot = 2 edges,  clk3 half = 8 edges.
   task automatic check_cycle(input int n);
      chk("clk2",      n, 32'(clk2),      (n / 8) % 2);
      chk("bit_idx",   n, 32'(bit_idx),   (n / 16) % 32);
      chk("clk3",      n, 32'(clk3),      (n / 512) % 2);
      chk("bclk_fall", n, 32'(bclk_fall), ((n % 16) == 0) ? 1 : 0);
      chk("lr_toggle", n, 32'(lr_toggle), ((n % 512) == 0) ? 1 : 0);
      chk("d2_clk2",      n, 32'(d2_clk2),      n % 2);
      chk("d2_bit_idx",   n, 32'(d2_bit_idx),   (n / 2) % 4);
      chk("d2_clk3",      n, 32'(d2_clk3),      (n / 8) % 2);
      chk("d2_bclk_fall", n, 32'(d2_bclk_fall), ((n % 2) == 0) ? 1 : 0);
      chk("d2_lr_toggle", n, 32'(d2_lr_toggle), ((n % 8) == 0) ? 1 : 0);
`ifdef LRCLK_MCLK_EN
      // first rise on edge 4, then high on edges with n%4 in {0,1}
      chk("mclk", n, 32'(mclk), ((n >= 4) && ((n % 4) < 2)) ? 1 : 0);
`endif
   endtask

   initial begin
      rst_n = 1'b0;

      // Reset hold: outputs stay at reset values while rst_n is low
      repeat (2) @(negedge clk);
      check_reset("rst_hold_a");
      @(negedge clk);
      check_reset("rst_hold_b");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;                       // released between rising edges

      // Free run: clk2 first rise at edge 8, fall at 16, clk3 toggles at
      // 512/1024/1536, strobes on each fall / each LRCK change.
      for (int n = 1; n <= 1810; n++) begin
         @(negedge clk);
         check_cycle(n);
      end

      // Mid-frame reset at bit slot 17 of the right channel
      chk("pre_rst_bit_idx", 1810, 32'(bit_idx), 17);
      chk("pre_rst_clk3",    1810, 32'(clk3),    1);
      #5 rst_n = 1'b0;
      #1 check_reset("async_rst");
      @(negedge clk);
      check_reset("rst_held");
      @(negedge clk);
      rst_n = 1'b1;

      // Full first frame after release: no short LRCK half
      for (int n = 1; n <= 600; n++) begin
         @(negedge clk);
         check_cycle(n);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
